// File: rtl/fetch_queue_pkg.sv
// Shared widths, pc_sig encodings and the queue entry layout for the fetch queue.
package fetch_queue_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;
    localparam int QDEPTH  = 4;
    localparam int PTR_W   = 2;
    localparam int CNT_W   = 3;
    localparam int ENTRY_W = INSTR_W + PC_W;

    // pc_sig encodings; 2'b00 is also treated as sequential
    localparam logic [1:0] PC_SEQ    = 2'b11;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_BRANCH = 2'b10;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
    } q_entry_t;

    // Builds a queue entry from an instruction word and its address.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [INSTR_W-1:0] instr,
                                                      input logic [PC_W-1:0]    pc);
        q_entry_t e;
        e.instr = instr;
        e.pc    = pc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_queue_inst_fifo.sv
// Four-entry instruction FIFO: push 0/1/2 words, pop 1 word, flush, occupancy count.
// State updates on the falling edge of clk.
module inst_fifo
    import fetch_queue_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               pop,
    input  logic [1:0]         push_cnt,
    input  logic [ENTRY_W-1:0] push_data0,
    input  logic [ENTRY_W-1:0] push_data1,
    output logic [ENTRY_W-1:0] head_data,
    output logic [CNT_W-1:0]   count
);

    logic [ENTRY_W-1:0] mem_q [QDEPTH];
    logic [ENTRY_W-1:0] mem_d [QDEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               pop_ok;
    logic [PTR_W-1:0]   tail_nx;

    assign pop_ok  = pop && (count_q != '0);
    assign tail_nx = tail_q + 2'd1;

    // Next-state for storage, pointers and count; flush wins over push and pop.
    always_comb begin
        for (int i = 0; i < QDEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem_d[tail_q] = push_data0;
            end
            if (push_cnt == 2'd2) begin
                mem_d[tail_nx] = push_data1;
            end
            tail_d  = tail_q + push_cnt;
            head_d  = head_q + {1'b0, pop_ok};
            count_d = count_q + {1'b0, push_cnt} - {2'b00, pop_ok};
        end
    end

    // Falling-edge storage and pointer registers with asynchronous clear.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_data = mem_q[head_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: fetches up to two words per edge into a 4-entry FIFO,
// redirects on jump/branch, and presents the head entry to decode.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         pc_sig,
    input  logic [PC_W-1:0]    dir_j,
    input  logic [PC_W-1:0]    dir_b,
    input  logic [INSTR_W-1:0] ins,
    input  logic [INSTR_W-1:0] ins2,
    output logic [PC_W-1:0]    fetch_addr,
    output logic [PC_W-1:0]    fetch_addr2,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [CNT_W-1:0]   q_count
);

    logic [PC_W-1:0]    fetch_addr_q, fetch_addr_d;
    logic [1:0]         push_cnt;
    logic               flush;
    logic               pop;
    logic [CNT_W-1:0]   free;
    logic [ENTRY_W-1:0] head_data;
    logic [ENTRY_W-1:0] push_data0;
    logic [ENTRY_W-1:0] push_data1;
    q_entry_t           head;

    assign fetch_addr2 = fetch_addr_q + 5'd1;
    assign fetch_addr  = fetch_addr_q;

    assign pop  = instr_valid && instr_ready;
    // Slots available this edge, counting the one freed by a pop (0..4).
    assign free = 3'd4 - q_count + {2'b00, pop};

    assign push_data0 = pack_entry(ins, fetch_addr_q);
    assign push_data1 = pack_entry(ins2, fetch_addr2);

    // PC advance/redirect and push sizing; a redirect flushes and pushes nothing.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        push_cnt     = 2'd0;
        flush        = 1'b0;
        case (pc_sig)
            PC_JUMP: begin
                flush        = 1'b1;
                fetch_addr_d = dir_j;
            end
            PC_BRANCH: begin
                flush        = 1'b1;
                fetch_addr_d = dir_b;
            end
            default: begin
                if (free >= 3'd2) begin
                    push_cnt     = 2'd2;
                    fetch_addr_d = fetch_addr_q + 5'd2;
                end else if (free == 3'd1) begin
                    push_cnt     = 2'd1;
                    fetch_addr_d = fetch_addr_q + 5'd1;
                end
            end
        endcase
    end

    // Falling-edge PC register; reset returns fetch to address 0.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_addr_q <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
        end
    end

    inst_fifo u_inst_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .pop        (pop),
        .push_cnt   (push_cnt),
        .push_data0 (push_data0),
        .push_data1 (push_data1),
        .head_data  (head_data),
        .count      (q_count)
    );

    // Head presentation; zeroed when the queue is empty.
    always_comb begin
        head        = q_entry_t'(head_data);
        instr_valid = (q_count != '0);
        instr_out   = '0;
        instr_pc    = '0;
        if (instr_valid) begin
            instr_out = head.instr;
            instr_pc  = head.pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: vector table plus hand-written reset/stall/wrap sequences.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic [1:0]  pc_sig;
    logic [4:0]  dir_j;
    logic [4:0]  dir_b;
    logic [31:0] ins;
    logic [31:0] ins2;
    logic [4:0]  fetch_addr;
    logic [4:0]  fetch_addr2;
    logic [31:0] instr_out;
    logic [4:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  q_count;

    int checks;
    int errors;

    fetch_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sig      (pc_sig),
        .dir_j       (dir_j),
        .dir_b       (dir_b),
        .ins         (ins),
        .ins2        (ins2),
        .fetch_addr  (fetch_addr),
        .fetch_addr2 (fetch_addr2),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .q_count     (q_count)
    );

    // Instruction memory model: word at address a is 0x1000_0000 + a.
    assign ins  = 32'h1000_0000 + {27'd0, fetch_addr};
    assign ins2 = 32'h1000_0000 + {27'd0, fetch_addr2};

    // Active edge is negedge (t=5,15,...); checks happen on posedge.
    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0] sig;
        logic [4:0] dj;
        logic [4:0] db;
        logic       rdy;
        logic [4:0] e_fa;
        logic [2:0] e_cnt;
        logic       e_valid;
        logic [4:0] e_pc;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic [1:0] sig, logic [4:0] dj, logic [4:0] db, logic rdy,
                                logic [4:0] e_fa, logic [2:0] e_cnt, logic e_valid, logic [4:0] e_pc);
        vec_t v;
        v.sig = sig; v.dj = dj; v.db = db; v.rdy = rdy;
        v.e_fa = e_fa; v.e_cnt = e_cnt; v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Full output check against an expected state; head word derived from the memory model.
    task automatic chk_state(input string tag, input logic [4:0] e_fa, input logic [2:0] e_cnt,
                             input logic e_valid, input logic [4:0] e_pc);
        logic [31:0] e_out;
        e_out = e_valid ? (32'h1000_0000 + {27'd0, e_pc}) : 32'h0;
        chk({tag, ".fetch_addr"},  {27'd0, fetch_addr},  {27'd0, e_fa});
        chk({tag, ".fetch_addr2"}, {27'd0, fetch_addr2}, {27'd0, 5'(e_fa + 5'd1)});
        chk({tag, ".q_count"},     {29'd0, q_count},     {29'd0, e_cnt});
        chk({tag, ".instr_valid"}, {31'd0, instr_valid}, {31'd0, e_valid});
        chk({tag, ".instr_out"},   instr_out,            e_out);
        chk({tag, ".instr_pc"},    {27'd0, instr_pc},    {27'd0, (e_valid ? e_pc : 5'd0)});
    endtask

    // Drive inputs after a posedge, let one active (falling) edge pass, then sample at posedge.
    task automatic step(input logic [1:0] sig, input logic [4:0] dj, input logic [4:0] db, input logic rdy);
        pc_sig      = sig;
        dir_j       = dj;
        dir_b       = db;
        instr_ready = rdy;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        pc_sig      = 2'b11;
        dir_j       = 5'd0;
        dir_b       = 5'd0;
        instr_ready = 1'b1;

        //                sig    dj     db     rdy  fa     cnt   vld   head pc
        vecs[0]  = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd2,  3'd2, 1'b1, 5'd0);
        vecs[1]  = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd4,  3'd3, 1'b1, 5'd1);
        vecs[2]  = mk(2'b11, 5'd0,  5'd0,  1'b0, 5'd5,  3'd4, 1'b1, 5'd1);
        vecs[3]  = mk(2'b11, 5'd0,  5'd0,  1'b0, 5'd5,  3'd4, 1'b1, 5'd1);
        vecs[4]  = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd6,  3'd4, 1'b1, 5'd2);
        vecs[5]  = mk(2'b01, 5'd17, 5'd3,  1'b0, 5'd17, 3'd0, 1'b0, 5'd0);
        vecs[6]  = mk(2'b11, 5'd0,  5'd0,  1'b0, 5'd19, 3'd2, 1'b1, 5'd17);
        vecs[7]  = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd21, 3'd3, 1'b1, 5'd18);
        vecs[8]  = mk(2'b10, 5'd9,  5'd31, 1'b1, 5'd31, 3'd0, 1'b0, 5'd0);
        vecs[9]  = mk(2'b11, 5'd0,  5'd0,  1'b0, 5'd1,  3'd2, 1'b1, 5'd31);
        vecs[10] = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd3,  3'd3, 1'b1, 5'd0);
        vecs[11] = mk(2'b00, 5'd0,  5'd0,  1'b1, 5'd5,  3'd4, 1'b1, 5'd1);
        vecs[12] = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd6,  3'd4, 1'b1, 5'd2);
        vecs[13] = mk(2'b01, 5'd30, 5'd0,  1'b1, 5'd30, 3'd0, 1'b0, 5'd0);
        vecs[14] = mk(2'b11, 5'd0,  5'd0,  1'b0, 5'd0,  3'd2, 1'b1, 5'd30);
        vecs[15] = mk(2'b11, 5'd0,  5'd0,  1'b1, 5'd2,  3'd3, 1'b1, 5'd31);

        // Reset state, held across several active edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_state("reset", 5'd0, 3'd0, 1'b0, 5'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].sig, vecs[i].dj, vecs[i].db, vecs[i].rdy);
            chk_state($sformatf("vec%0d", i), vecs[i].e_fa, vecs[i].e_cnt, vecs[i].e_valid, vecs[i].e_pc);
        end

        // Stall from reset: queue fills to 4, PC holds, then one accepted pop lets one word in.
        do_reset();
        step(2'b11, 5'd0, 5'd0, 1'b0);
        chk_state("stall.e1", 5'd2, 3'd2, 1'b1, 5'd0);
        step(2'b11, 5'd0, 5'd0, 1'b0);
        chk_state("stall.e2", 5'd4, 3'd4, 1'b1, 5'd0);
        step(2'b11, 5'd0, 5'd0, 1'b0);
        chk_state("stall.e3", 5'd4, 3'd4, 1'b1, 5'd0);
        step(2'b11, 5'd0, 5'd0, 1'b1);
        chk_state("full.pop", 5'd5, 3'd4, 1'b1, 5'd1);

        // Jump with 3 entries, then the first fetch from the target.
        do_reset();
        step(2'b11, 5'd0, 5'd0, 1'b0);
        step(2'b11, 5'd0, 5'd0, 1'b1);
        chk_state("pre_jump", 5'd4, 3'd3, 1'b1, 5'd1);
        step(2'b01, 5'd17, 5'd0, 1'b0);
        chk_state("jump", 5'd17, 3'd0, 1'b0, 5'd0);
        step(2'b11, 5'd0, 5'd0, 1'b0);
        chk_state("jump.next", 5'd19, 3'd2, 1'b1, 5'd17);

        // Asynchronous reset mid-cycle with 3 entries: outputs clear with no clock edge.
        do_reset();
        step(2'b11, 5'd0, 5'd0, 1'b0);
        step(2'b11, 5'd0, 5'd0, 1'b1);
        chk_state("pre_arst", 5'd4, 3'd3, 1'b1, 5'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_state("arst", 5'd0, 3'd0, 1'b0, 5'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(2'b11, 5'd0, 5'd0, 1'b1);
        chk_state("arst.release", 5'd2, 3'd2, 1'b1, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its falling edge.
REQ-002 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port pc_sig, input, 2: PC control; 01 = jump, 10 = branch taken, 00/11 = sequential.
REQ-004 SHALL have port dir_j, input, 5: jump target word address.
REQ-005 SHALL have port dir_b, input, 5: branch target word address.
REQ-006 SHALL have port ins, input, 32: instruction memory word at fetch_addr.
REQ-007 SHALL have port ins2, input, 32: instruction memory word at fetch_addr2.
REQ-008 SHALL have port fetch_addr, output, 5: fetch word address (the PC).
REQ-009 SHALL have port fetch_addr2, output, 5: fetch_addr+1 mod 32.
REQ-010 SHALL have port instr_out, output, 32: queue head instruction, to the IF/ID register.
REQ-011 SHALL have port instr_pc, output, 5: address of instr_out.
REQ-012 SHALL have port instr_valid, output, 1: head entry valid.
REQ-013 SHALL have port instr_ready, input, 1: decode accepts head this edge (low = stall).
REQ-014 SHALL have port q_count, output, 3: occupied entries, 0..4.

Function
REQ-015 SHALL hold a 4-entry FIFO of {instruction[31:0], pc[4:0]}.
REQ-016 SHALL treat a pop as occurring at an edge only when instr_valid=1 and instr_ready=1.
REQ-017 SHALL compute free = 4 - q_count + pop (0..4) at each edge.
REQ-018 SHALL on a sequential edge with free>=2: push ins@fetch_addr, then ins2@fetch_addr2; fetch_addr += 2.
REQ-019 SHALL on a sequential edge with free==1: push ins only; fetch_addr += 1.
REQ-020 SHALL on a sequential edge with free==0: push nothing; fetch_addr holds.
REQ-021 SHALL on pc_sig=01: flush all entries, push nothing, fetch_addr <= dir_j.
REQ-022 SHALL on pc_sig=10: flush all entries, push nothing, fetch_addr <= dir_b.
REQ-023 SHALL give redirect priority over push/pop; a head popped on a redirect edge counts as consumed; q_count=0 after the edge.
REQ-024 SHALL wrap all address arithmetic modulo 32 (31+1=0, 31+2=1).
REQ-025 SHALL drive instr_out, instr_pc, instr_valid combinationally from the registered head; instr_valid = (q_count!=0).
REQ-026 SHALL drive instr_out=0 and instr_pc=0 when the queue is empty.
REQ-027 SHALL have latency: an instruction fetched at edge N is visible at instr_out after edge N if the queue was empty.
REQ-028 SHALL never overflow or underflow; q_count SHALL change by (pushes - pop) only.

Reset
REQ-029 SHALL, while rst_n=0, force fetch_addr=0, q_count=0, instr_valid=0, instr_out=0, instr_pc=0, with head/tail pointers cleared.
REQ-030 SHALL discard all queue contents on rst_n assertion mid-operation; the first edge after release fetches from address 0.

Structure
REQ-031 SHALL place shared constants in a package: PC_W=5, INSTR_W=32, QDEPTH=4, and pc_sig encodings PC_SEQ=11, PC_JUMP=01, PC_BRANCH=10.
REQ-032 SHALL use one sub-module, inst_fifo: 4-entry FIFO with 0/1/2-word push, 1-word pop, flush, and count.
REQ-033 SHALL keep the redirect/advance logic for fetch_addr in fetch_queue itself.

Verification
REQ-034 SHALL verify reset release, ready=1, memory word = 0x1000_0000+addr: after edge 1, fetch_addr=2, q_count=2, instr_out=0x10000000, instr_pc=0.
REQ-035 SHALL verify stall (ready=0) from reset: edges 1,2 -> q_count 2,4, fetch_addr 4; edge 3 -> q_count=4, fetch_addr=4 (held).
REQ-036 SHALL verify full queue with ready=1 for one edge: exactly one push (ins@4), fetch_addr=5, q_count=4.
REQ-037 SHALL verify jump: pc_sig=01, dir_j=17 with 3 entries -> q_count=0, instr_valid=0, fetch_addr=17; next sequential edge -> instr_pc=17, q_count=2.
REQ-038 SHALL verify wrap: branch with dir_b=31, then one sequential edge -> entries at pc 31, 0; fetch_addr=1.
REQ-039 SHALL verify rst_n asserted with q_count=3 mid-edge-cycle -> outputs zero immediately, before any clk edge.
